// File: rtl/cpu_arb_pkg.sv
// Shared definitions for the SRAM bus arbiter.
//   ARB_ID_INST / ARB_ID_DATA : transaction owner IDs carried in the ID FIFO
//   OUTST_DEPTH_DFLT          : default number of outstanding bus transactions
//   arb_req_t                 : one master's request bundle
package cpu_arb_pkg;

    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    localparam int OUTST_DEPTH_DFLT = 2;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } arb_req_t;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like bus port: request fields flow master->slave, handshakes and
// read data flow slave->master.
//   req, wr, size, addr, wdata, wstrb : request bundle (master drives)
//   addr_ok, data_ok, rdata           : address accept, response, read data
interface sram_bus_arbiter_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata, wstrb,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata, wstrb,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/arb_id_fifo.sv
// 1-bit-wide synchronous FIFO recording the owner of each accepted bus
// transaction in issue order.
//   clk, resetn : clock, synchronous active-low reset
//   push, din   : write din at the tail (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   head        : owner ID at the head
//   full, empty : derived from the registered count only
module arb_id_fifo
    import cpu_arb_pkg::*;
#(
    parameter int DEPTH = OUTST_DEPTH_DFLT
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // push+pop together leaves the count alone
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one shared SRAM-like
// bus and routes each response back to the master that issued it.
//   clk, resetn : clock, synchronous active-low reset
//   inst        : IF-port (slave side of the CPU's fetch master)
//   data        : data load/store port (slave side)
//   sram        : shared bus (master side)
//   OUTST_DEPTH : max accepted-but-unanswered bus transactions
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration between
// the two ports; otherwise the data port has fixed priority.
module sram_bus_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int OUTST_DEPTH = OUTST_DEPTH_DFLT
) (
    input  logic                      clk,
    input  logic                      resetn,
    sram_bus_arbiter_if.slave         inst,
    sram_bus_arbiter_if.slave         data,
    sram_bus_arbiter_if.master        sram
);

    arb_req_t inst_rq, data_rq, sel_rq;
    logic     grant;
    logic     sram_req;
    logic     hs;
    logic     resp_vld;
    logic     fifo_full, fifo_empty, fifo_head;
    logic     lock_vld_q, lock_vld_d;
    logic     lock_id_q, lock_id_d;
`ifdef SRAM_ARB_RR_EN
    logic     last_id_q, last_id_d;
`endif

    assign inst_rq = '{req: inst.req, wr: inst.wr, size: inst.size,
                       addr: inst.addr, wdata: inst.wdata, wstrb: inst.wstrb};
    assign data_rq = '{req: data.req, wr: data.wr, size: data.size,
                       addr: data.addr, wdata: data.wdata, wstrb: data.wstrb};

    // A held lock pins the grant so a backpressured request stays stable.
    always_comb begin
        grant = ARB_ID_INST;
        if (lock_vld_q) begin
            grant = lock_id_q;
        end else if (inst_rq.req && data_rq.req) begin
`ifdef SRAM_ARB_RR_EN
            grant = ~last_id_q;
`else
            grant = ARB_ID_DATA;
`endif
        end else if (data_rq.req) begin
            grant = ARB_ID_DATA;
        end
    end

    assign sel_rq   = (grant == ARB_ID_DATA) ? data_rq : inst_rq;
    assign sram_req = resetn & sel_rq.req & ~fifo_full;
    assign hs       = sram_req & sram.addr_ok;

    assign sram.req   = sram_req;
    assign sram.wr    = sel_rq.wr;
    assign sram.size  = sel_rq.size;
    assign sram.addr  = sel_rq.addr;
    assign sram.wdata = sel_rq.wdata;
    assign sram.wstrb = sel_rq.wstrb;

    assign inst.addr_ok = hs & (grant == ARB_ID_INST);
    assign data.addr_ok = hs & (grant == ARB_ID_DATA);

    // A response with nothing outstanding is dropped rather than misrouted.
    assign resp_vld     = resetn & sram.data_ok & ~fifo_empty;
    assign inst.data_ok = resp_vld & (fifo_head == ARB_ID_INST);
    assign data.data_ok = resp_vld & (fifo_head == ARB_ID_DATA);
    assign inst.rdata   = sram.rdata;
    assign data.rdata   = sram.rdata;

    arb_id_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (hs),
        .din    (grant),
        .pop    (resetn & sram.data_ok),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        if (hs) begin
            lock_vld_d = 1'b0;
        end else if (sram_req) begin
            lock_vld_d = 1'b1;
            lock_id_d  = grant;
        end
    end

`ifdef SRAM_ARB_RR_EN
    assign last_id_d = hs ? grant : last_id_q;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= ARB_ID_INST;
`ifdef SRAM_ARB_RR_EN
            last_id_q  <= ARB_ID_DATA;
`endif
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
`ifdef SRAM_ARB_RR_EN
            last_id_q  <= last_id_d;
`endif
        end
    end

    a_no_orphan_resp: assert property (
        @(posedge clk) disable iff (!resetn) sram.data_ok |-> !fifo_empty
    ) else $error("sram_data_ok with no outstanding transaction");

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with an in-order response scoreboard.
module tb_sram_bus_arbiter;
    import cpu_arb_pkg::*;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    sram_bus_arbiter_if inst_bus ();
    sram_bus_arbiter_if data_bus ();
    sram_bus_arbiter_if sram_bus ();

    sram_bus_arbiter #(
        .OUTST_DEPTH (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .inst   (inst_bus),
        .data   (data_bus),
        .sram   (sram_bus)
    );

    typedef struct {
        logic        id;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic check_ok(input string tag, input logic ia, input logic da,
                            input logic id, input logic dd);
        check_eq({tag, "_inst_addr_ok"}, {31'd0, inst_bus.addr_ok}, {31'd0, ia});
        check_eq({tag, "_data_addr_ok"}, {31'd0, data_bus.addr_ok}, {31'd0, da});
        check_eq({tag, "_inst_data_ok"}, {31'd0, inst_bus.data_ok}, {31'd0, id});
        check_eq({tag, "_data_data_ok"}, {31'd0, data_bus.data_ok}, {31'd0, dd});
    endtask

    task automatic exp_push(input logic id, input logic [31:0] rdata);
        exp_t e;
        e.id    = id;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic idle_all();
        inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd2;
        inst_bus.addr = '0; inst_bus.wdata = '0; inst_bus.wstrb = '0;
        data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd2;
        data_bus.addr = '0; data_bus.wdata = '0; data_bus.wstrb = '0;
        sram_bus.addr_ok = 1'b0; sram_bus.data_ok = 1'b0; sram_bus.rdata = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        idle_all();
        nxt();
        resetn = 1'b1;
        exp_q.delete();
    endtask

    // Response monitor: every routed data_ok must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && (inst_bus.data_ok || data_bus.data_ok)) begin
            check_eq("resp_one_hot", {31'd0, inst_bus.data_ok & data_bus.data_ok}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("resp_port", {31'd0, data_bus.data_ok}, {31'd0, e.id});
                check_eq("resp_rdata", data_bus.data_ok ? data_bus.rdata : inst_bus.rdata,
                         e.rdata);
            end
        end
    end

    logic exp_g [2];

    initial begin
        // reset forces handshakes low even with everything asserted
        resetn = 1'b0;
        idle_all();
        inst_bus.req = 1'b1;
        data_bus.req = 1'b1;
        sram_bus.addr_ok = 1'b1;
        sram_bus.data_ok = 1'b1;
        #1;
        check_eq("rst_sram_req", {31'd0, sram_bus.req}, 32'd0);
        check_ok("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        nxt();
        apply_reset();

        // data-only read
        data_bus.req = 1'b1; data_bus.addr = 32'h1000; sram_bus.addr_ok = 1'b1;
        exp_push(ARB_ID_DATA, 32'hDEADBEEF);
        #1;
        check_eq("t1_sram_req", {31'd0, sram_bus.req}, 32'd1);
        check_eq("t1_sram_addr", sram_bus.addr, 32'h1000);
        check_ok("t1_req", 1'b0, 1'b1, 1'b0, 1'b0);
        nxt();
        data_bus.req = 1'b0; sram_bus.addr_ok = 1'b0;
        #1;
        check_ok("t1_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        nxt();
        sram_bus.data_ok = 1'b1; sram_bus.rdata = 32'hDEADBEEF;
        #1;
        check_ok("t1_resp", 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t1_rdata", data_bus.rdata, 32'hDEADBEEF);
        nxt();
        sram_bus.data_ok = 1'b0;

        // both requesting
        apply_reset();
`ifdef SRAM_ARB_RR_EN
        exp_g[0] = ARB_ID_INST; exp_g[1] = ARB_ID_DATA;
`else
        exp_g[0] = ARB_ID_DATA; exp_g[1] = ARB_ID_DATA;
`endif
        inst_bus.req = 1'b1; inst_bus.addr = 32'h2000;
        data_bus.req = 1'b1; data_bus.addr = 32'h3000;
        sram_bus.addr_ok = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_push(exp_g[k], 32'hA0 + 32'(k));
            #1;
            check_eq("t2_sram_req", {31'd0, sram_bus.req}, 32'd1);
            check_eq("t2_inst_grant", {31'd0, inst_bus.addr_ok}, {31'd0, exp_g[k] == ARB_ID_INST});
            check_eq("t2_data_grant", {31'd0, data_bus.addr_ok}, {31'd0, exp_g[k] == ARB_ID_DATA});
            check_eq("t2_sram_addr", sram_bus.addr,
                     (exp_g[k] == ARB_ID_DATA) ? 32'h3000 : 32'h2000);
            nxt();
        end
        inst_bus.req = 1'b0; data_bus.req = 1'b0; sram_bus.addr_ok = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sram_bus.data_ok = 1'b1; sram_bus.rdata = 32'hA0 + 32'(k);
            nxt();
        end
        sram_bus.data_ok = 1'b0;

        // lock under backpressure: IF write held, data arrives a cycle later
        apply_reset();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h4000; inst_bus.wr = 1'b1;
        inst_bus.wdata = 32'hCAFEF00D; inst_bus.wstrb = 4'hF;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                data_bus.req = 1'b1; data_bus.addr = 32'h5000;
            end
            #1;
            check_eq("t3_hold_addr", sram_bus.addr, 32'h4000);
            check_eq("t3_hold_req", {31'd0, sram_bus.req}, 32'd1);
            check_eq("t3_hold_wr", {31'd0, sram_bus.wr}, 32'd1);
            check_eq("t3_hold_wdata", sram_bus.wdata, 32'hCAFEF00D);
            check_ok("t3_hold", 1'b0, 1'b0, 1'b0, 1'b0);
            nxt();
        end
        sram_bus.addr_ok = 1'b1;
        exp_push(ARB_ID_INST, 32'h33);
        #1;
        check_eq("t3_accept_addr", sram_bus.addr, 32'h4000);
        check_ok("t3_accept", 1'b1, 1'b0, 1'b0, 1'b0);
        nxt();
        inst_bus.req = 1'b0; inst_bus.wr = 1'b0;
        exp_push(ARB_ID_DATA, 32'h44);
        #1;
        check_eq("t3_next_addr", sram_bus.addr, 32'h5000);
        check_ok("t3_next", 1'b0, 1'b1, 1'b0, 1'b0);
        nxt();
        data_bus.req = 1'b0; sram_bus.addr_ok = 1'b0;
        sram_bus.data_ok = 1'b1; sram_bus.rdata = 32'h33;
        nxt();
        sram_bus.rdata = 32'h44;
        nxt();
        sram_bus.data_ok = 1'b0;

        // full FIFO stalls the bus; one-cycle bubble after the pop
        apply_reset();
        data_bus.req = 1'b1; sram_bus.addr_ok = 1'b1;
        for (int k = 0; k < 2; k++) begin
            data_bus.addr = 32'h8000 + 32'(4 * k);
            exp_push(ARB_ID_DATA, 32'hB0 + 32'(k));
            #1;
            check_eq("t4_fill_req", {31'd0, sram_bus.req}, 32'd1);
            nxt();
        end
        data_bus.addr = 32'h8008;
        #1;
        check_eq("t4_full_req", {31'd0, sram_bus.req}, 32'd0);
        check_eq("t4_full_aok", {31'd0, data_bus.addr_ok}, 32'd0);
        nxt();
        sram_bus.data_ok = 1'b1; sram_bus.rdata = 32'hB0;
        #1;
        check_eq("t4_bubble_req", {31'd0, sram_bus.req}, 32'd0);
        check_eq("t4_bubble_dok", {31'd0, data_bus.data_ok}, 32'd1);
        nxt();
        sram_bus.data_ok = 1'b0;
        exp_push(ARB_ID_DATA, 32'hB2);
        #1;
        check_eq("t4_resume_req", {31'd0, sram_bus.req}, 32'd1);
        check_eq("t4_resume_aok", {31'd0, data_bus.addr_ok}, 32'd1);
        nxt();
        data_bus.req = 1'b0; sram_bus.addr_ok = 1'b0;
        sram_bus.data_ok = 1'b1; sram_bus.rdata = 32'hB1;
        nxt();
        sram_bus.rdata = 32'hB2;
        nxt();
        sram_bus.data_ok = 1'b0;

        // ordering: IF read then data read
        apply_reset();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h6000; sram_bus.addr_ok = 1'b1;
        exp_push(ARB_ID_INST, 32'h11111111);
        #1;
        check_ok("t5_if", 1'b1, 1'b0, 1'b0, 1'b0);
        nxt();
        inst_bus.req = 1'b0; data_bus.req = 1'b1; data_bus.addr = 32'h7000;
        exp_push(ARB_ID_DATA, 32'h22222222);
        #1;
        check_ok("t5_data", 1'b0, 1'b1, 1'b0, 1'b0);
        nxt();
        data_bus.req = 1'b0; sram_bus.addr_ok = 1'b0;
        sram_bus.data_ok = 1'b1; sram_bus.rdata = 32'h11111111;
        #1;
        check_ok("t5_resp0", 1'b0, 1'b0, 1'b1, 1'b0);
        nxt();
        sram_bus.rdata = 32'h22222222;
        #1;
        check_ok("t5_resp1", 1'b0, 1'b0, 1'b0, 1'b1);
        nxt();
        sram_bus.data_ok = 1'b0;

        // reset with a data transaction outstanding
        apply_reset();
        data_bus.req = 1'b1; data_bus.addr = 32'h9000; sram_bus.addr_ok = 1'b1;
        #1;
        check_ok("t6_issue", 1'b0, 1'b1, 1'b0, 1'b0);
        nxt();
        data_bus.req = 1'b0;
        resetn = 1'b0;
        inst_bus.req = 1'b1; inst_bus.addr = 32'hA000;
        sram_bus.data_ok = 1'b1; sram_bus.rdata = 32'h55;
        #1;
        check_eq("t6_rst_sram_req", {31'd0, sram_bus.req}, 32'd0);
        check_ok("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        nxt();
        resetn = 1'b1;
        inst_bus.req = 1'b0; sram_bus.addr_ok = 1'b0; sram_bus.data_ok = 1'b0;
        #1;
        check_eq("t6_fifo_empty", {31'd0, dut.u_fifo.empty}, 32'd1);
        check_ok("t6_after", 1'b0, 1'b0, 1'b0, 1'b0);
        nxt();
        inst_bus.req = 1'b1; sram_bus.addr_ok = 1'b1;
        exp_push(ARB_ID_INST, 32'h66);
        #1;
        check_ok("t6_new", 1'b1, 1'b0, 1'b0, 1'b0);
        nxt();
        inst_bus.req = 1'b0; sram_bus.addr_ok = 1'b0;
        sram_bus.data_ok = 1'b1; sram_bus.rdata = 32'h66;
        #1;
        check_ok("t6_resp", 1'b0, 1'b0, 1'b1, 1'b0);
        nxt();
        sram_bus.data_ok = 1'b0;
        nxt();

        check_eq("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Arbitrates the CPU's instruction-fetch port and data load/store port onto one shared SRAM-like bus. It sits between the IF/EX-stage request logic and the external bus. It tracks outstanding transactions in issue order so each `data_ok`/`rdata` returns to the master that issued it. All decision state is registered; request and response paths are combinational pass-throughs.

## Interface
- `OUTST_DEPTH`, default 2: maximum accepted-but-unanswered transactions on the shared bus (power of two, ≥1).
- `clk` input 1: single clock, all state on rising edge.
- `resetn` input 1: synchronous, active-low reset.
- `inst_req`, `inst_wr` input 1: IF-port request and write flag.
- `inst_size` input 2: IF-port transfer size.
- `inst_addr`, `inst_wdata` input 32: IF-port address and write data.
- `inst_wstrb` input 4: IF-port byte strobes.
- `inst_addr_ok`, `inst_data_ok` output 1: IF-port handshakes.
- `inst_rdata` output 32: IF-port read data.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`, `data_wstrb`, `data_addr_ok`, `data_data_ok`, `data_rdata`: data port, same widths and meanings as the IF port.
- `sram_req`, `sram_wr` output 1: shared-bus request and write flag.
- `sram_size` output 2: shared-bus transfer size.
- `sram_addr`, `sram_wdata` output 32: shared-bus address and write data.
- `sram_wstrb` output 4: shared-bus byte strobes.
- `sram_addr_ok`, `sram_data_ok` input 1: shared-bus handshakes.
- `sram_rdata` input 32: shared-bus read data.

## Operation
- Masters hold `*_req` and the request fields stable until they see `*_addr_ok`. The bus slave returns `data_ok` in issue order.
- **Grant, combinational.**
  - If `lock_vld`=1, grant = `lock_id`.
  - Otherwise, if only one port requests, grant that port.
  - If both request, grant per the arbitration policy (see Configuration).
- **Forwarding.** `sram_req` = granted port's `req` AND NOT `fifo_full`. All other `sram_*` request fields mux from the granted port (IF port when nothing is granted).
- **Address acknowledge.** The granted port's `addr_ok` = `sram_addr_ok` AND `sram_req`. The non-granted port's `addr_ok` = 0.
- **Lock.** Set `lock_vld`=1 and `lock_id`=grant when `sram_req`=1 and `sram_addr_ok`=0. Clear the lock on the `sram_req` AND `sram_addr_ok` handshake. The lock keeps the bus request stable across slave backpressure.
- **ID FIFO.** Depth `OUTST_DEPTH`, 1-bit entries (0 = IF, 1 = data).
  - Push the grant ID on the `sram_req` AND `sram_addr_ok` handshake.
  - Pop on `sram_data_ok`.
  - `fifo_full` is computed from registered count only, so a simultaneous pop does not enable a push that cycle.
- **Response routing.**
  - `sram_data_ok` routes to the port named by the FIFO head.
  - `rdata` is broadcast to both ports; only the qualified `data_ok` matters.
  - `sram_data_ok` with the FIFO empty is a protocol error: ignore it, and assert in simulation.
- **Simultaneous events.** Push and pop in the same cycle leave the count unchanged and advance both pointers. Pointers wrap modulo `OUTST_DEPTH`.

## Timing
- Zero-cycle combinational latency from port request to `sram_*` and from `sram_*_ok` to port handshakes. There is no added pipeline stage.
- Back-to-back handshakes are allowed every cycle until the FIFO fills. When full, `sram_req`=0 until a `data_ok` has been registered (one-cycle bubble after the pop).
- **Reset (`resetn`=0 at clock edge).** FIFO pointers and count become 0, `lock_vld`=0, `last_id`=1. Within the reset cycle, `sram_req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok` and `data_data_ok` are forced to 0.
- Reset mid-transaction discards all tracking. The external bus must be reset in the same cycle.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin. A 1-bit `last_id` register updates on each handshake. With both ports requesting and no lock, grant goes to NOT `last_id`.
- Not defined: fixed priority, data port first. `last_id` is not implemented.
- The lock overrides either policy.

## Structure
- Package `cpu_arb_pkg` holds:
  - localparams `ARB_ID_INST`=0 and `ARB_ID_DATA`=1;
  - the default `OUTST_DEPTH`;
  - a struct for the request bundle (`req`, `wr`, `size`, `addr`, `wdata`, `wstrb`).
- Sub-module `arb_id_fifo`: synchronous 1-bit-wide FIFO with push, pop, head, full and empty outputs, and a `DEPTH` parameter. It is instantiated once.

## Test plan
- **Data-only.** `data_req`=1, `data_addr`=0x1000, slave `addr_ok` immediate and `data_ok` 2 cycles later with `rdata`=0xDEADBEEF. Expect `data_addr_ok` in the request cycle, `data_data_ok`=1 with `data_rdata`=0xDEADBEEF after 2 cycles, and both `inst_*_ok`=0 throughout.
- **Both requesting, fixed priority.** Both ports request with immediate `addr_ok`. Without `SRAM_ARB_RR_EN`, expect the data port granted for 2 consecutive cycles. With `SRAM_ARB_RR_EN`, expect grants to alternate: IF (since `last_id`=1 after reset), then data.
- **Lock under backpressure.** Slave holds `addr_ok`=0 for 3 cycles while IF is granted; data asserts `req` in cycle 1. Expect `sram_addr` to stay at the IF address for all 3 cycles, then data granted next.
- **Full FIFO.** With `OUTST_DEPTH`=2, issue 2 reads and withhold `data_ok`. Expect `sram_req`=0 on the third request. After one `data_ok`, expect `sram_req` to reassert the following cycle.
- **Ordering.** Issue IF read then data read; slave returns `data_ok` with rdata 0x11111111 then 0x22222222. Expect `inst_data_ok` for the first and `data_data_ok` for the second.
- **Reset mid-flight.** Assert `resetn`=0 with 1 outstanding transaction. Next cycle expect the FIFO empty and all `*_ok` outputs 0. A new request afterwards is granted normally.
